pipe_hazard_ctrl: RTL and testbench

//   Consumer side of the hazard-detection stall request in the 5-stage pipeline. Turns

---
 rtl/pipe_hazard_ctrl_if.sv | 35 +++
 rtl/pipe_hazard_ctrl.sv | 107 ++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: hazard-control bus between fetch/hazard logic and pipe_hazard_ctrl
//   master drives: stall_req, redirect, redirect_pc, if_pc, if_instr
//   slave drives:  pc_we, pc_sel, pc_target, idex_bubble, id_pc, id_instr, id_valid,
//                  stall_cnt, flush_cnt, stall_timeout
interface pipe_hazard_ctrl_if #(
    parameter int XLEN = 32
);
    logic            stall_req;
    logic            redirect;
    logic [XLEN-1:0] redirect_pc;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_instr;
    logic            pc_we;
    logic            pc_sel;
    logic [XLEN-1:0] pc_target;
    logic            idex_bubble;
    logic [XLEN-1:0] id_pc;
    logic [31:0]     id_instr;
    logic            id_valid;
    logic [31:0]     stall_cnt;
    logic [31:0]     flush_cnt;
    logic            stall_timeout;

    modport master (
        output stall_req, redirect, redirect_pc, if_pc, if_instr,
        input  pc_we, pc_sel, pc_target, idex_bubble, id_pc, id_instr, id_valid,
               stall_cnt, flush_cnt, stall_timeout
    );

    modport slave (
        input  stall_req, redirect, redirect_pc, if_pc, if_instr,
        output pc_we, pc_sel, pc_target, idex_bubble, id_pc, id_instr, id_valid,
               stall_cnt, flush_cnt, stall_timeout
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: turns stall requests and EX redirects into PC control and ID/EX bubbles,
//   owns the IF/ID register, counts stalls/redirects and flags overly long stall runs.
//   clk   - rising-edge clock
//   rstn  - synchronous reset, active low
//   bus   - pipe_hazard_ctrl_if.slave (stall/redirect/fetch in; PC control, IF/ID, counters out)
module pipe_hazard_ctrl #(
    parameter int          XLEN       = 32,
    parameter int          SQUASH_CYC = 2,
    parameter int          MAX_STALL  = 15,
    parameter logic [31:0] NOP_INSTR  = 32'h00000013
) (
    input  logic              clk,
    input  logic              rstn,
    pipe_hazard_ctrl_if.slave bus
);
    localparam int SW = $clog2(SQUASH_CYC + 1);
    localparam int RW = $clog2(MAX_STALL + 2);
    localparam logic [RW-1:0] RUN_MAX = RW'(MAX_STALL + 1);

    typedef enum logic [1:0] {RUN, STALL, SQUASH} state_t;

    state_t          r_state, w_state;
    logic [SW-1:0]   r_squash_left, w_squash_left;
    logic [RW-1:0]   r_stall_run, w_stall_run;
    logic [XLEN-1:0] r_id_pc, w_id_pc;
    logic [31:0]     r_id_instr, w_id_instr;
    logic            r_id_valid, w_id_valid;
    logic [31:0]     r_stall_cnt, w_stall_cnt;
    logic [31:0]     r_flush_cnt, w_flush_cnt;
    logic            r_timeout, w_timeout;

    // Redirect always wins: the PC must take the target even if a stall is requested.
    assign bus.pc_sel        = bus.redirect;
    assign bus.pc_target     = bus.redirect_pc;
    assign bus.pc_we         = bus.redirect | ~bus.stall_req;
    assign bus.idex_bubble   = bus.redirect | bus.stall_req;
    assign bus.id_pc         = r_id_pc;
    assign bus.id_instr      = r_id_instr;
    assign bus.id_valid      = r_id_valid;
    assign bus.stall_cnt     = r_stall_cnt;
    assign bus.flush_cnt     = r_flush_cnt;
    assign bus.stall_timeout = r_timeout;

    always_comb begin
        w_state       = r_state;
        w_squash_left = r_squash_left;
        w_stall_run   = r_stall_run;
        w_id_pc       = r_id_pc;
        w_id_instr    = r_id_instr;
        w_id_valid    = r_id_valid;
        w_stall_cnt   = r_stall_cnt;
        w_flush_cnt   = r_flush_cnt;
        w_timeout     = r_timeout;
        if (bus.redirect) begin
            // A stall coinciding with a redirect came from a wrong-path instruction: drop it.
            w_id_pc       = bus.if_pc;
            w_id_instr    = NOP_INSTR;
            w_id_valid    = 1'b0;
            w_flush_cnt   = r_flush_cnt + 32'd1;
            w_squash_left = SW'(SQUASH_CYC - 1);
            w_state       = (SQUASH_CYC > 1) ? SQUASH : RUN;
            w_stall_run   = '0;
        end else if (r_state == SQUASH) begin
            // Still fetching down the wrong path; stall requests are irrelevant here.
            w_id_pc       = bus.if_pc;
            w_id_instr    = NOP_INSTR;
            w_id_valid    = 1'b0;
            w_squash_left = r_squash_left - SW'(1);
            w_state       = (r_squash_left == SW'(1)) ? RUN : SQUASH;
        end else if (bus.stall_req) begin
            w_stall_cnt = r_stall_cnt + 32'd1;
            w_stall_run = (r_stall_run == RUN_MAX) ? r_stall_run : r_stall_run + RW'(1);
            w_timeout   = r_timeout | (w_stall_run == RUN_MAX);
            w_state     = STALL;
        end else begin
            w_id_pc     = bus.if_pc;
            w_id_instr  = bus.if_instr;
            w_id_valid  = 1'b1;
            w_stall_run = '0;
            w_state     = RUN;
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            r_state       <= RUN;
            r_squash_left <= '0;
            r_stall_run   <= '0;
            r_id_pc       <= '0;
            r_id_instr    <= NOP_INSTR;
            r_id_valid    <= 1'b0;
            r_stall_cnt   <= '0;
            r_flush_cnt   <= '0;
            r_timeout     <= 1'b0;
        end else begin
            r_state       <= w_state;
            r_squash_left <= w_squash_left;
            r_stall_run   <= w_stall_run;
            r_id_pc       <= w_id_pc;
            r_id_instr    <= w_id_instr;
            r_id_valid    <= w_id_valid;
            r_stall_cnt   <= w_stall_cnt;
            r_flush_cnt   <= w_flush_cnt;
            r_timeout     <= w_timeout;
        end
    end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and randomized scoreboard bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    localparam int          SQUASH_CYC = 2;
    localparam int          MAX_STALL  = 15;
    localparam logic [31:0] NOP        = 32'h00000013;

    typedef struct {
        logic        pc_we, pc_sel, idex_bubble, id_valid, to;
        logic [31:0] pc_target, id_pc, id_instr, sc, fc;
    } exp_t;

    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.XLEN(32)) bus();

    pipe_hazard_ctrl #(
        .XLEN(32), .SQUASH_CYC(SQUASH_CYC), .MAX_STALL(MAX_STALL), .NOP_INSTR(NOP)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus.slave)
    );

    exp_t sb[$];
    int n_cmp = 0, n_bad = 0, n_push = 0, n_pop = 0;

    // reference state: what the IF/ID register and counters should hold
    logic [31:0] m_pc, m_ins, m_sc, m_fc;
    logic        m_val, m_to;
    int          m_sq, m_run;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(input logic rn, input logic st, input logic rd,
                        input logic [31:0] rpc, input logic [31:0] pc, input logic [31:0] ins);
        exp_t e;
        @(negedge clk);
        rstn = rn;
        bus.stall_req = st;
        bus.redirect = rd;
        bus.redirect_pc = rpc;
        bus.if_pc = pc;
        bus.if_instr = ins;
        e.pc_we = rd | ~st;
        e.pc_sel = rd;
        e.pc_target = rpc;
        e.idex_bubble = rd | st;
        if (!rn) begin
            m_pc = 0; m_ins = NOP; m_val = 0; m_sc = 0; m_fc = 0; m_sq = 0; m_run = 0; m_to = 0;
        end else if (rd) begin
            m_pc = pc; m_ins = NOP; m_val = 0; m_fc++; m_sq = SQUASH_CYC - 1; m_run = 0;
        end else if (m_sq > 0) begin
            m_pc = pc; m_ins = NOP; m_val = 0; m_sq--;
        end else if (st) begin
            m_sc++;
            if (m_run <= MAX_STALL) m_run++;
            if (m_run == MAX_STALL + 1) m_to = 1;
        end else begin
            m_pc = pc; m_ins = ins; m_val = 1; m_run = 0;
        end
        e.id_pc = m_pc; e.id_instr = m_ins; e.id_valid = m_val;
        e.sc = m_sc; e.fc = m_fc; e.to = m_to;
        sb.push_back(e);
        n_push++;
        @(posedge clk);
        #3;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_pop++;
                chk("pc_we", 32'(bus.pc_we), 32'(e.pc_we));
                chk("pc_sel", 32'(bus.pc_sel), 32'(e.pc_sel));
                chk("pc_target", bus.pc_target, e.pc_target);
                chk("idex_bubble", 32'(bus.idex_bubble), 32'(e.idex_bubble));
                chk("id_pc", bus.id_pc, e.id_pc);
                chk("id_instr", bus.id_instr, e.id_instr);
                chk("id_valid", 32'(bus.id_valid), 32'(e.id_valid));
                chk("stall_cnt", bus.stall_cnt, e.sc);
                chk("flush_cnt", bus.flush_cnt, e.fc);
                chk("stall_timeout", 32'(bus.stall_timeout), 32'(e.to));
            end
        end
    end

    initial begin
        logic st, rd, rn;
        rstn = 1'b0;
        bus.stall_req = 0; bus.redirect = 0; bus.redirect_pc = 0; bus.if_pc = 0; bus.if_instr = 0;
        // T1 reset
        step(0, 0, 0, 0, 32'h40, 32'h11111111);
        step(0, 0, 0, 0, 32'h44, 32'h22222222);
        chk("t1_id_instr", bus.id_instr, 32'h00000013);
        chk("t1_id_valid", 32'(bus.id_valid), 0);
        chk("t1_pc_we", 32'(bus.pc_we), 1);
        chk("t1_stall_cnt", bus.stall_cnt, 0);
        chk("t1_flush_cnt", bus.flush_cnt, 0);
        // T2 flow
        step(1, 0, 0, 0, 32'h100, 32'h00A00093);
        chk("t2_id_pc", bus.id_pc, 32'h100);
        chk("t2_id_instr", bus.id_instr, 32'h00A00093);
        chk("t2_id_valid", 32'(bus.id_valid), 1);
        // T3 load-use stall
        step(1, 0, 0, 0, 32'h104, 32'h00208133);
        step(1, 1, 0, 0, 32'h108, 32'h003101B3);
        chk("t3_pc_we", 32'(bus.pc_we), 0);
        chk("t3_bubble", 32'(bus.idex_bubble), 1);
        chk("t3_id_pc_hold", bus.id_pc, 32'h104);
        chk("t3_stall_cnt", bus.stall_cnt, 1);
        step(1, 0, 0, 0, 32'h108, 32'h003101B3);
        chk("t3_id_pc_next", bus.id_pc, 32'h108);
        chk("t3_id_instr_next", bus.id_instr, 32'h003101B3);
        // T4 redirect
        step(1, 0, 1, 32'h200, 32'h10C, 32'h0000006F);
        chk("t4_pc_sel", 32'(bus.pc_sel), 1);
        chk("t4_pc_target", bus.pc_target, 32'h200);
        chk("t4_valid0", 32'(bus.id_valid), 0);
        chk("t4_nop0", bus.id_instr, NOP);
        chk("t4_flush_cnt", bus.flush_cnt, 1);
        step(1, 1, 0, 0, 32'h110, 32'h00000033);
        chk("t4_valid1", 32'(bus.id_valid), 0);
        chk("t4_squash_no_stall", bus.stall_cnt, 1);
        step(1, 0, 0, 0, 32'h200, 32'h00500293);
        chk("t4_resume", 32'(bus.id_valid), 1);
        chk("t4_resume_pc", bus.id_pc, 32'h200);
        // T5 collision
        step(1, 1, 1, 32'h300, 32'h204, 32'h00000013);
        chk("t5_pc_we", 32'(bus.pc_we), 1);
        chk("t5_stall_cnt", bus.stall_cnt, 1);
        chk("t5_valid", 32'(bus.id_valid), 0);
        chk("t5_flush_cnt", bus.flush_cnt, 2);
        step(1, 0, 0, 0, 32'h304, 32'h0);
        // T6 watchdog
        step(0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 32'h400, 32'h00000093);
        for (int i = 0; i < 15; i++) step(1, 1, 0, 0, 32'h404, 32'h0);
        chk("t6_not_yet", 32'(bus.stall_timeout), 0);
        step(1, 1, 0, 0, 32'h404, 32'h0);
        chk("t6_timeout", 32'(bus.stall_timeout), 1);
        chk("t6_stall_cnt", bus.stall_cnt, 16);
        step(1, 0, 0, 0, 32'h404, 32'h0);
        step(1, 0, 0, 0, 32'h408, 32'h0);
        chk("t6_sticky", 32'(bus.stall_timeout), 1);
        step(0, 0, 0, 0, 0, 0);
        chk("t6_cleared", 32'(bus.stall_timeout), 0);
        // randomized traffic with alternating short and long stall phases
        for (int i = 0; i < 1500; i++) begin
            rn = ($urandom % 100) != 0;
            st = ((i / 150) % 2 == 1) ? (($urandom % 10) != 0) : (($urandom % 3) == 0);
            rd = ($urandom % 9) == 0;
            step(rn, st, rd, $urandom, $urandom, $urandom);
        end
        repeat (3) @(posedge clk);
        #4;
        chk("sb_drain", 32'(n_pop), 32'(n_push));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
